sfx_scheduler: RTL and testbench

Sits between the game controller and the sigma-delta audio engine. It latches single-cycle sound requests, arbitrates them by priority and presents exactly one event level to the engine at a time. Each event is held long enough to span an engine sample tick, then further requests are locked out until the sound has finished. Requests are never lost while the engine is busy, unless they are explicitly coalesced or discarded as specified below.

---
 rtl/sfx_scheduler.sv | 143 ++++++++++++++
 tb/tb_sfx_scheduler.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/sfx_scheduler.sv
// Sound-effect request scheduler: latches request pulses, arbitrates by priority
// (death > highscore > jump) and holds one event level per sound, then locks out.
module sfx_scheduler #(
  parameter int SAMPLE_DIV = 1024,
  parameter int JUMP_LEN   = 5764,
  parameter int DEATH_LEN  = 12004,
  parameter int HIGH_LEN   = 13446
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_jump,
  input  logic       req_death,
  input  logic       req_highscore,
  input  logic       game_running,
  input  logic       mute,
  output logic       event_jump,
  output logic       event_death,
  output logic       event_highscore,
  output logic       busy,
  output logic [1:0] active_type,
  output logic [7:0] drop_count
);

  localparam int IW = $clog2(SAMPLE_DIV + 1);
  localparam int DW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(SAMPLE_DIV - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, PLAY} state_t;

  state_t          state, state_n;
  logic [1:0]      type_n;
  logic [IW-1:0]   issue_cnt, issue_cnt_n;
  logic [15:0]     play_cnt, play_cnt_n;
  logic [DW-1:0]   div;
  logic            tick;
  logic            pend_j, pend_d, pend_h;
  logic            pend_j_n, pend_d_n, pend_h_n;
  logic            set_j, set_d, set_h;
  logic            sel_j, sel_d, sel_h;
  logic [9:0]      drop_sum;
  logic [7:0]      drop_n;

  assign tick = (div == DIV_MAX);

  always_comb begin
    state_n     = state;
    type_n      = active_type;
    issue_cnt_n = issue_cnt;
    play_cnt_n  = play_cnt;
    sel_j       = 1'b0;
    sel_d       = 1'b0;
    sel_h       = 1'b0;

    case (state)
      IDLE: begin
        if (pend_d) begin
          sel_d  = 1'b1;
          type_n = 2'd2;
        end else if (pend_h) begin
          sel_h  = 1'b1;
          type_n = 2'd3;
        end else if (pend_j && game_running) begin
          sel_j  = 1'b1;
          type_n = 2'd1;
        end
        if (sel_j || sel_d || sel_h) begin
          issue_cnt_n = IW'(SAMPLE_DIV);
          state_n     = ISSUE;
        end
      end
      ISSUE: begin
        if (issue_cnt == '0) begin
          state_n = PLAY;
          case (active_type)
            2'd1:    play_cnt_n = 16'(JUMP_LEN);
            2'd2:    play_cnt_n = 16'(DEATH_LEN);
            2'd3:    play_cnt_n = 16'(HIGH_LEN);
            default: play_cnt_n = '0;
          endcase
        end else begin
          issue_cnt_n = issue_cnt - 1'b1;
        end
      end
      PLAY: begin
        if (play_cnt == '0) begin
          state_n = IDLE;
          type_n  = 2'd0;
        end else if (tick) begin
          play_cnt_n = play_cnt - 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        type_n  = 2'd0;
      end
    endcase

    // A new request beats any clear on the same edge (issue, flush, game stop).
    set_j    = req_jump && !mute && game_running;
    set_d    = req_death && !mute;
    set_h    = req_highscore && !mute;
    pend_j_n = set_j || (pend_j && !(sel_j || set_d || !game_running));
    pend_d_n = set_d || (pend_d && !sel_d);
    pend_h_n = set_h || (pend_h && !sel_h);

    drop_sum = {2'b00, drop_count} + 10'(set_j && pend_j)
             + 10'(set_d && pend_d) + 10'(set_h && pend_h);
    drop_n   = (drop_sum > 10'd255) ? 8'hFF : drop_sum[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      active_type     <= 2'd0;
      issue_cnt       <= '0;
      play_cnt        <= '0;
      div             <= '0;
      pend_j          <= 1'b0;
      pend_d          <= 1'b0;
      pend_h          <= 1'b0;
      drop_count      <= '0;
      busy            <= 1'b0;
      event_jump      <= 1'b0;
      event_death     <= 1'b0;
      event_highscore <= 1'b0;
    end else begin
      state           <= state_n;
      active_type     <= type_n;
      issue_cnt       <= issue_cnt_n;
      play_cnt        <= play_cnt_n;
      div             <= tick ? '0 : div + 1'b1;
      pend_j          <= pend_j_n;
      pend_d          <= pend_d_n;
      pend_h          <= pend_h_n;
      drop_count      <= drop_n;
      busy            <= (state_n != IDLE);
      event_jump      <= (state_n == ISSUE) && (type_n == 2'd1);
      event_death     <= (state_n == ISSUE) && (type_n == 2'd2);
      event_highscore <= (state_n == ISSUE) && (type_n == 2'd3);
    end
  end

endmodule

// File: tb/tb_sfx_scheduler.sv
// Directed bench for sfx_scheduler with SAMPLE_DIV=8, JUMP_LEN=3, DEATH_LEN=5, HIGH_LEN=6.
module tb_sfx_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_jump = 1'b0, req_death = 1'b0, req_highscore = 1'b0;
  logic       game_running = 1'b1, mute = 1'b0;
  logic       event_jump, event_death, event_highscore, busy;
  logic [1:0] active_type;
  logic [7:0] drop_count;

  int n_vec = 0;
  int n_bad = 0;

  sfx_scheduler #(.SAMPLE_DIV(8), .JUMP_LEN(3), .DEATH_LEN(5), .HIGH_LEN(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_jump(req_jump), .req_death(req_death), .req_highscore(req_highscore),
    .game_running(game_running), .mute(mute),
    .event_jump(event_jump), .event_death(event_death), .event_highscore(event_highscore),
    .busy(busy), .active_type(active_type), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One-cycle request pulse; returns on the negedge after the sampling edge.
  task automatic req(input logic j, input logic d, input logic h);
    @(negedge clk);
    req_jump = j; req_death = d; req_highscore = h;
    @(negedge clk);
    req_jump = 1'b0; req_death = 1'b0; req_highscore = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int max);
    int n = 0;
    while (busy === 1'b1 && n < max) begin
      @(negedge clk);
      n++;
    end
    chk(tag, busy, 0);
  endtask

  task automatic quiet(input string tag, input int n);
    int b = 0;
    repeat (n) begin
      @(negedge clk);
      b += int'(busy | event_jump | event_death | event_highscore);
    end
    chk(tag, b, 0);
  endtask

  // Called on the first negedge with busy high; returns on the first idle negedge.
  task automatic run_event(input logic [1:0] typ, input int len, input string tag);
    int hi = 0, bz = 0, other = 0, tbad = 0;
    logic mine;
    while (busy === 1'b1 && bz < 300) begin
      mine  = (typ == 2'd1) ? event_jump : (typ == 2'd2) ? event_death : event_highscore;
      hi   += int'(mine);
      other += int'(event_jump) + int'(event_death) + int'(event_highscore) - int'(mine);
      if (active_type !== typ) tbad++;
      bz++;
      @(negedge clk);
    end
    chk({tag, "_hold"}, hi, 9);
    chk({tag, "_other_ev"}, other, 0);
    chk({tag, "_type"}, tbad, 0);
    chk({tag, "_lockout_ok"}, (bz >= 8 * len + 1) && (bz <= 8 * len + 17), 1);
    chk({tag, "_type_idle"}, active_type, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_events", {event_jump, event_death, event_highscore}, 0);
    chk("rst_type", active_type, 0);
    chk("rst_drop", drop_count, 0);
    rst_n = 1'b1;
    quiet("rst_idle", 4);

    // single jump
    req(1, 0, 0);
    chk("jump_latency", event_jump, 0);
    @(negedge clk);
    chk("jump_ev", event_jump, 1);
    chk("jump_busy", busy, 1);
    chk("jump_type", active_type, 1);
    run_event(2'd1, 3, "jump");
    chk("jump_drop", drop_count, 0);

    // priority: highscore first, jump after one idle cycle
    req(1, 0, 1);
    @(negedge clk);
    chk("prio_first", active_type, 3);
    run_event(2'd3, 6, "prio_h");
    @(negedge clk);
    chk("prio_b2b_busy", busy, 1);
    chk("prio_b2b_type", active_type, 1);
    run_event(2'd1, 3, "prio_j");

    // death flushes a pending jump
    req(0, 0, 1);
    @(negedge clk);
    chk("flush_h_type", active_type, 3);
    repeat (12) @(negedge clk);
    req(1, 0, 0);
    repeat (2) @(negedge clk);
    req(0, 1, 0);
    wait_idle("flush_h_done", 100);
    @(negedge clk);
    chk("flush_d_type", active_type, 2);
    run_event(2'd2, 5, "flush_d");
    quiet("flush_no_jump", 20);

    // coalesce three jumps during death PLAY
    req(0, 1, 0);
    @(negedge clk);
    chk("coal_d_type", active_type, 2);
    repeat (12) @(negedge clk);
    req(1, 0, 0);
    req(1, 0, 0);
    req(1, 0, 0);
    chk("coal_drop2", drop_count, 2);
    wait_idle("coal_d_done", 100);
    @(negedge clk);
    chk("coal_j_type", active_type, 1);
    run_event(2'd1, 3, "coal_j");
    quiet("coal_single_jump", 20);

    // saturation: request held for 300 edges
    @(negedge clk);
    req_jump = 1'b1;
    repeat (300) @(negedge clk);
    req_jump = 1'b0;
    game_running = 1'b0;
    chk("drop_sat", drop_count, 255);
    wait_idle("sat_drain", 200);
    quiet("gr0_no_jump_pending", 10);

    // mute discards, game_running=0 blocks only jumps
    mute = 1'b1;
    req(0, 1, 0);
    quiet("mute_death", 15);
    mute = 1'b0;
    req(1, 0, 0);
    quiet("gr0_jump", 15);
    req(0, 0, 1);
    @(negedge clk);
    chk("gr0_high_busy", busy, 1);
    chk("gr0_high_type", active_type, 3);
    wait_idle("gr0_high_done", 100);
    game_running = 1'b1;

    // reset in the middle of a death ISSUE with jump/highscore pending
    req(0, 1, 0);
    @(negedge clk);
    chk("rmid_ev_d", event_death, 1);
    req(1, 0, 1);
    chk("rmid_ev_d_held", event_death, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rmid_ev_d_drop", event_death, 0);
    chk("rmid_busy", busy, 0);
    chk("rmid_type", active_type, 0);
    chk("rmid_drop", drop_count, 0);
    chk("rmid_events", {event_jump, event_highscore}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    quiet("rmid_no_pending", 20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
